// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: 34-cycle latency, or 1 cycle for divide-by-zero/overflow.
// No backpressure: start is taken only in IDLE and ignored while busy; flush aborts to IDLE.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic            op_rem;
  logic            neg_q;
  logic            neg_r;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            ovf;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[XLEN-1];
    b_neg     = is_signed & b[XLEN-1];
    a_abs     = a_neg ? -a : a;
    b_abs     = b_neg ? -b : b;
    ovf       = is_signed && (a == MIN_INT) && (b == {XLEN{1'b1}});
    // rem < divisor always fits XLEN bits, so the shifted value needs one extra bit;
    // the borrow out of the XLEN+1-bit subtract is the compare result.
    rem_sh    = {rem, quo[XLEN-1]};
    diff      = rem_sh - {1'b0, dvs};
    ge        = ~diff[XLEN];
    quo_fix   = neg_q ? -quo : quo;
    rem_fix   = neg_r ? -rem : rem;
  end

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      op_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_rem <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            if (b == '0) begin
              result <= op[1] ? a : {XLEN{1'b1}};
              state  <= S_DONE;
            end else if (ovf) begin
              result <= op[1] ? '0 : MIN_INT;
              state  <= S_DONE;
            end else begin
              quo   <= a_abs;
              dvs   <= b_abs;
              rem   <= '0;
              cnt   <= CW'(XLEN);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          quo <= {quo[XLEN-2:0], ge};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          result <= op_rem ? rem_fix : quo_fix;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: directed RV32M cases, flush/reset aborts, and a random sweep.
module tb_div_unit;

  localparam logic [31:0] MIN = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", tag, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'h0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.tag, "_result"}, result, e.res);
        check({e.tag, "_latency"}, 32'(cyc), 32'(e.at));
      end
    end
  end

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return o[1] ? x : ONES;
    if (!o[0] && x == MIN && y == ONES) return o[1] ? 32'h0 : MIN;
    case (o)
      2'd0:    return $signed(x) / $signed(y);
      2'd1:    return x / y;
      2'd2:    return $signed(x) % $signed(y);
      default: return x % y;
    endcase
  endfunction

  task automatic wait_done(input string tag, output int nbusy);
    bit seen = 0;
    nbusy = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) seen = 1;
    end
    if (!seen) check({tag, "_done_timeout"}, {31'b0, done}, 32'h1);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] r, input string tag, input bit chk_busy);
    int s, lat, nb;
    lat = (y == 0 || (!o[0] && x == MIN && y == ONES)) ? 1 : 34;
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    s = cyc;
    sbq.push_back('{r, s + lat, tag});
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(tag, nb);
    if (chk_busy) check({tag, "_busy_cycles"}, 32'(nb), 32'(lat - 1));
  endtask

  logic [31:0] corner [7] = '{32'h0, 32'h1, ONES, MIN, 32'h7FFF_FFFF, 32'h7, 32'hFFFF_FFF9};

  initial begin
    int s, nb;
    logic [31:0] x, y;
    logic [1:0]  o;

    #1;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(2'd1, 32'd100, 32'd7, 32'd14, "divu_100_7", 1);
    run(2'd3, 32'd100, 32'd7, 32'd2, "remu_100_7", 1);
    run(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2", 1);
    run(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2", 0);
    run(2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2", 0);
    run(2'd2, 32'd7, 32'hFFFF_FFFE, 32'h1, "rem_7_m2", 0);
    run(2'd0, MIN, ONES, MIN, "div_ovf", 1);
    run(2'd2, MIN, ONES, 32'h0, "rem_ovf", 1);
    run(2'd1, MIN, ONES, 32'h0, "divu_min_ones", 1);
    run(2'd3, MIN, ONES, MIN, "remu_min_ones", 0);
    run(2'd1, 32'd5, 32'd0, ONES, "divu_by0", 1);
    run(2'd2, 32'd5, 32'd0, 32'd5, "rem_by0", 1);

    // Flush mid-CALC: no done, result keeps the previous value (5).
    @(posedge clk); #1;
    op = 2'd0; a = 32'd1000; b = 32'd3; start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < s + 10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'h0);
    check("flush_done", {31'b0, done}, 32'h0);
    check("flush_result", result, 32'd5);
    repeat (40) @(negedge clk);

    // Start and flush together: start is dropped.
    @(posedge clk); #1;
    op = 2'd1; a = 32'd9; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {31'b0, busy}, 32'h0);
    repeat (4) @(negedge clk);

    // Start while busy is ignored; operands are not re-sampled.
    @(posedge clk); #1;
    op = 2'd1; a = 32'd1000; b = 32'd3; start = 1'b1;
    s = cyc;
    sbq.push_back('{32'd333, s + 34, "busy_ignore"});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 op = 2'd0; a = 32'hFFFF_FFCE; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_ignore", nb);
    repeat (3) @(negedge clk);
    run(2'd2, 32'hFFFF_FFCE, 32'd7, 32'hFFFF_FFFF, "rem_m50_7", 0);
    run(2'd0, 32'hFFFF_FFCE, 32'd7, 32'hFFFF_FFF9, "div_m50_7", 0);

    // Asynchronous reset mid-CALC clears outputs at once.
    @(posedge clk); #1;
    op = 2'd1; a = 32'd77; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_done", {31'b0, done}, 32'h0);
    check("arst_result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run(2'd1, 32'd77, 32'd4, 32'd19, "divu_after_reset", 1);

    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 6)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 6)] : $urandom;
      if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(1, 28);
      run(o, x, y, ref_div(o, x, y), "rand", 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
